sseg_src_arbiter: RTL and testbench

//  Shares the 3-digit seven-segment display between two BCD sources (A, B).

---
 rtl/sseg_pkg.sv | 24 ++
 rtl/sseg_hold_timer.sv | 37 +++
 rtl/sseg_src_arbiter.sv | 129 ++++++++++++
 tb/tb_sseg_src_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Types and helpers shared by the seven-segment display path: the arbiter,
// the BCD incrementor and the multiplexing driver.
package sseg_pkg;

    localparam int BCD_W = 12;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/sseg_hold_timer.sv
// Minimum-hold timer for a display grant: loads HOLD_CYCLES-1 and counts down,
// sticking at zero. A grant may only be reconsidered once expired is high.
module sseg_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 300000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sseg_src_arbiter.sv
// Round-robin owner selection between two BCD sources for the shared display,
// with a minimum hold per grant so the shown digits never flicker.
module sseg_src_arbiter
    import sseg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 300000,
    parameter bcd_t        IDLE_BCD    = 12'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [11:0] bcd_a,
    input  logic       req_b,
    input  logic [11:0] bcd_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [11:0] bcd_out,
    output logic       busy
);

    arb_state_t state_q, state_d;
    src_t       last_q, last_d;
    bcd_t       bcd_q, bcd_d;
    logic       gnt_a_q, gnt_b_q, busy_q;
    logic       load;
    logic       expired;
    logic       start_a;
    logic       start_b;

    sseg_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        load    = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        case (state_q)
            IDLE: begin
                // A tie goes to whichever source did not hold the last grant.
                if (req_a && (!req_b || last_q == SRC_B)) begin
                    start_a = 1'b1;
                end else if (req_b) begin
                    start_b = 1'b1;
                end else begin
                    bcd_d = IDLE_BCD;
                end
            end
            OWN_A: begin
                if (expired) begin
                    if (req_b) begin
                        start_b = 1'b1;
                    end else if (req_a) begin
                        bcd_d = bcd_a;
                    end else begin
                        state_d = IDLE;
                        bcd_d   = IDLE_BCD;
                    end
                end else if (req_a) begin
                    bcd_d = bcd_a;
                end
            end
            OWN_B: begin
                if (expired) begin
                    if (req_a) begin
                        start_a = 1'b1;
                    end else if (req_b) begin
                        bcd_d = bcd_b;
                    end else begin
                        state_d = IDLE;
                        bcd_d   = IDLE_BCD;
                    end
                end else if (req_b) begin
                    bcd_d = bcd_b;
                end
            end
            default: begin
                state_d = IDLE;
                bcd_d   = IDLE_BCD;
            end
        endcase

        // A fresh grant always restarts the hold window and shows the new digits at once.
        if (start_a) begin
            state_d = OWN_A;
            last_d  = SRC_A;
            load    = 1'b1;
            bcd_d   = bcd_a;
        end else if (start_b) begin
            state_d = OWN_B;
            last_d  = SRC_B;
            load    = 1'b1;
            bcd_d   = bcd_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC_B;
            bcd_q   <= IDLE_BCD;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            gnt_a_q <= (state_d == OWN_A);
            gnt_b_q <= (state_d == OWN_B);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign busy    = busy_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_sseg_src_arbiter.sv
// Bench for sseg_src_arbiter with HOLD_CYCLES=4: directed scenarios plus a
// randomized run checked against an owner/age reference model.
module tb_sseg_src_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0;
    logic [11:0] bcd_a = '0;
    logic        req_b = 1'b0;
    logic [11:0] bcd_b = '0;
    logic        gnt_a;
    logic        gnt_b;
    logic [11:0] bcd_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner 0=none 1=A 2=B, age = cycles owned so far.
    int          m_owner;
    int          m_age;
    int          m_last;
    logic [11:0] m_bcd;

    sseg_src_arbiter #(
        .HOLD_CYCLES(HOLD),
        .IDLE_BCD   (12'h000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .bcd_a  (bcd_a),
        .req_b  (req_b),
        .bcd_b  (bcd_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .bcd_out(bcd_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_age   = 0;
        m_last  = 2;
        m_bcd   = 12'h000;
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        m_age   = 1;
        m_last  = who;
        m_bcd   = (who == 1) ? bcd_a : bcd_b;
    endtask

    task automatic model_step();
        logic mine, theirs;
        if (m_owner == 0) begin
            if (req_a && req_b)  model_grant(m_last == 1 ? 2 : 1);
            else if (req_a)      model_grant(1);
            else if (req_b)      model_grant(2);
            else                 m_bcd = 12'h000;
        end else begin
            mine   = (m_owner == 1) ? req_a : req_b;
            theirs = (m_owner == 1) ? req_b : req_a;
            if (m_age >= HOLD && theirs) begin
                model_grant(3 - m_owner);
            end else if (m_age >= HOLD && !mine) begin
                m_owner = 0;
                m_age   = 0;
                m_bcd   = 12'h000;
            end else begin
                m_age = m_age + 1;
                if (mine) m_bcd = (m_owner == 1) ? bcd_a : bcd_b;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        bcd_a = '0;
        bcd_b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({gnt_a, gnt_b, busy} !== 3'b000 || bcd_out !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: gnt_a=%b gnt_b=%b busy=%b bcd=%h, required 0 0 0 000", gnt_a, gnt_b, busy, bcd_out);
        end
        req_a = 1'b1;
        bcd_a = 12'h123;
        cyc();
        cyc();
        n_tests++;
        if (gnt_a !== 1'b1 || bcd_out !== 12'h123) begin
            n_fail++;
            $display("FAIL pre_abort_grant: gnt_a=%b bcd=%h, required 1 123", gnt_a, bcd_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({gnt_a, gnt_b, busy} !== 3'b000 || bcd_out !== 12'h000) begin
            n_fail++;
            $display("FAIL async_abort: gnt_a=%b gnt_b=%b busy=%b bcd=%h, required 0 0 0 000", gnt_a, gnt_b, busy, bcd_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc();
        n_tests++;
        if (gnt_a !== 1'b1 || busy !== 1'b1 || bcd_out !== 12'h123) begin
            n_fail++;
            $display("FAIL regrant_after_reset: gnt_a=%b busy=%b bcd=%h, required 1 1 123", gnt_a, busy, bcd_out);
        end
    endtask

    task automatic test_alternation();
        logic exp_a;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        bcd_a = 12'h111;
        bcd_b = 12'h222;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp_a = (((k - 1) / HOLD) % 2) == 0;
            n_tests++;
            if (gnt_a !== exp_a || gnt_b !== !exp_a || busy !== 1'b1 ||
                bcd_out !== (exp_a ? 12'h111 : 12'h222)) begin
                n_fail++;
                $display("FAIL alternation cycle %0d: gnt_a=%b gnt_b=%b busy=%b bcd=%h, required %b %b 1 %h",
                         k, gnt_a, gnt_b, busy, bcd_out, exp_a, !exp_a, exp_a ? 12'h111 : 12'h222);
            end
        end
    endtask

    task automatic test_drop_freeze();
        do_reset();
        req_a = 1'b1;
        bcd_a = 12'h042;
        cyc();
        req_a = 1'b0;
        bcd_a = 12'h999;
        for (int k = 2; k <= 5; k++) begin
            cyc();
            n_tests++;
            if (k <= HOLD) begin
                if (gnt_a !== 1'b1 || bcd_out !== 12'h042) begin
                    n_fail++;
                    $display("FAIL freeze cycle %0d: gnt_a=%b bcd=%h, required 1 042", k, gnt_a, bcd_out);
                end
            end else if ({gnt_a, gnt_b, busy} !== 3'b000 || bcd_out !== 12'h000) begin
                n_fail++;
                $display("FAIL release_idle: gnt_a=%b gnt_b=%b busy=%b bcd=%h, required 0 0 0 000", gnt_a, gnt_b, busy, bcd_out);
            end
        end
    endtask

    task automatic test_single_tracking();
        do_reset();
        req_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bcd_b = to_bcd(i);
            cyc();
            n_tests++;
            if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || bcd_out !== to_bcd(i)) begin
                n_fail++;
                $display("FAIL tracking step %0d: gnt_b=%b gnt_a=%b bcd=%h, required 1 0 %h", i, gnt_b, gnt_a, bcd_out, to_bcd(i));
            end
        end
    endtask

    task automatic test_switch();
        do_reset();
        req_a = 1'b1;
        bcd_a = 12'h0a0;
        bcd_b = 12'h0b0;
        cyc();
        req_b = 1'b1;
        for (int k = 2; k <= HOLD + 1; k++) begin
            cyc();
            n_tests++;
            if (k <= HOLD) begin
                if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL switch_hold cycle %0d: gnt_a=%b gnt_b=%b, required 1 0", k, gnt_a, gnt_b);
                end
            end else if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || busy !== 1'b1 || bcd_out !== 12'h0b0) begin
                n_fail++;
                $display("FAIL switch_edge: gnt_a=%b gnt_b=%b busy=%b bcd=%h, required 0 1 1 0b0", gnt_a, gnt_b, busy, bcd_out);
            end
        end
    endtask

    task automatic test_random();
        int prev_owner = 0;
        int cur_owner;
        int run_len = 0;
        int wait_a = 0;
        int wait_b = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            bcd_a = 12'($urandom);
            bcd_b = 12'($urandom);
            cyc();
            n_tests++;
            if (gnt_a !== (m_owner == 1) || gnt_b !== (m_owner == 2) || bcd_out !== m_bcd) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: gnt_a=%b gnt_b=%b bcd=%h, required %b %b %h",
                         c, gnt_a, gnt_b, bcd_out, m_owner == 1, m_owner == 2, m_bcd);
            end
            n_tests++;
            if ((gnt_a && gnt_b) || busy !== (gnt_a | gnt_b)) begin
                n_fail++;
                $display("FAIL random_onehot_busy cycle %0d: gnt_a=%b gnt_b=%b busy=%b, required onehot0 and busy=or", c, gnt_a, gnt_b, busy);
            end
            cur_owner = gnt_a ? 1 : (gnt_b ? 2 : 0);
            if (cur_owner == prev_owner) begin
                run_len++;
            end else begin
                n_tests++;
                if (prev_owner != 0 && run_len < HOLD) begin
                    n_fail++;
                    $display("FAIL random_min_hold cycle %0d: grant length %0d, required >= %0d", c, run_len, HOLD);
                end
                run_len = 1;
            end
            prev_owner = cur_owner;
            wait_a = (req_a && !gnt_a) ? wait_a + 1 : 0;
            wait_b = (req_b && !gnt_b) ? wait_b + 1 : 0;
            n_tests++;
            if (wait_a > 8 || wait_b > 8) begin
                n_fail++;
                $display("FAIL random_starvation cycle %0d: wait_a=%0d wait_b=%0d, required <= 8", c, wait_a, wait_b);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alternation();
        test_drop_freeze();
        test_single_tracking();
        test_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
